// File: rtl/pipe_field_collision.sv
// Pipe obstacle generator, field scroller, collision and score logic.
// Define PIPE_LFSR_EN to draw gap positions from a 16-bit LFSR instead of the fixed 3,6,9,6 cycle.
module pipe_field_collision #(
    parameter int COLS       = 16,
    parameter int BIRD_COL   = 2,
    parameter int TICK_W     = 10,
    parameter int SPACING    = 5,
    parameter int GAP        = 4,
    parameter int DEAD_TICKS = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [15:0]        bird_row,
    output logic [COLS*16-1:0] field,
    output logic               die,
    output logic               running,
    output logic [7:0]         score
);

    localparam int SW = (SPACING > 1) ? $clog2(SPACING) : 1;
    localparam int DW = $clog2(DEAD_TICKS + 1);
    localparam logic [15:0] GAP_ONES = 16'((1 << GAP) - 1);
    localparam logic [SW-1:0] SPAWN_LAST = SW'(SPACING - 1);
    localparam logic [DW-1:0] DEAD_LAST = DW'(DEAD_TICKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DEAD
    } state_t;

    state_t state;
    logic [TICK_W-1:0] tick_cnt;
    logic [SW-1:0] spawn_cnt;
    logic [DW-1:0] dead_cnt;
    logic [15:0] bird_col;
    logic [15:0] new_col;
    logic [3:0] g;
    logic tick;
    logic hit;
    logic scroll;
    logic spawn_now;
    logic restart;

    assign tick      = &tick_cnt;
    assign bird_col  = field[BIRD_COL*16 +: 16];
    assign hit       = (state == RUN) && ((|(bird_col & bird_row)) || (bird_row == 16'h0000));
    assign scroll    = (state == RUN) && start && tick && !hit;
    assign spawn_now = (spawn_cnt == SPAWN_LAST);
    assign restart   = (state == IDLE) && start;
    assign new_col   = spawn_now ? ~(GAP_ONES << g) : 16'h0000;
    assign running   = (state == RUN);

`ifdef PIPE_LFSR_EN
    logic [15:0] lfsr;
    logic fb;

    assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign g  = {1'b0, lfsr[2:0]} + 4'd2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (scroll && spawn_now) begin
            lfsr <= {lfsr[14:0], fb};
        end
    end
`else
    logic [1:0] gidx;

    always_comb begin
        g = 4'd3;
        unique case (gidx)
            2'd0: g = 4'd3;
            2'd1: g = 4'd6;
            2'd2: g = 4'd9;
            default: g = 4'd6;
        endcase
    end

    // First spawn of every game starts the cycle at gap row 3
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gidx <= 2'd0;
        end else if (restart) begin
            gidx <= 2'd0;
        end else if (scroll && spawn_now) begin
            gidx <= gidx + 2'd1;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            field     <= '0;
            die       <= 1'b0;
            score     <= 8'd0;
            tick_cnt  <= '0;
            spawn_cnt <= '0;
            dead_cnt  <= '0;
        end else begin
            die      <= hit;
            tick_cnt <= tick_cnt + 1'b1;
            unique case (state)
                IDLE: begin
                    field <= '0;
                    if (start) begin
                        state     <= RUN;
                        score     <= 8'd0;
                        spawn_cnt <= '0;
                    end
                end
                RUN: begin
                    if (hit) begin
                        state    <= DEAD;
                        dead_cnt <= '0;
                    end else if (scroll) begin
                        field <= {new_col, field[COLS*16-1:16]};
                        spawn_cnt <= spawn_now ? '0 : spawn_cnt + 1'b1;
                        if (bird_col != 16'h0000 && score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end
                end
                DEAD: begin
                    if (tick) begin
                        if (dead_cnt == DEAD_LAST) begin
                            state    <= IDLE;
                            field    <= '0;
                            dead_cnt <= '0;
                        end else begin
                            dead_cnt <= dead_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_field_collision.sv
// Directed bench for pipe_field_collision, fixed gap-cycle build, tick every 4 clocks.
module tb_pipe_field_collision;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [15:0] bird_row = 16'h0000;
    logic [255:0] field;
    logic die;
    logic running;
    logic [7:0] score;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [255:0] exp_f;

    pipe_field_collision #(
        .COLS(16),
        .BIRD_COL(2),
        .TICK_W(2),
        .SPACING(5),
        .GAP(4),
        .DEAD_TICKS(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .bird_row(bird_row),
        .field(field),
        .die(die),
        .running(running),
        .score(score)
    );

    always #5 clock = ~clock;

    function automatic logic [255:0] col_at(input int c, input logic [15:0] v);
        col_at = 256'(v) << (c * 16);
    endfunction

    // Release reset on a falling edge; the next rising edge is edge 1
    task automatic do_reset(input logic s, input logic [15:0] b);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start = s;
        bird_row = b;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic goto(input int e);
        while (cyc < e) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (field !== '0) begin errors++; $display("FAIL rst_field got %h expected 0", field); end
        checks++; if (die !== 1'b0) begin errors++; $display("FAIL rst_die got %b expected 0", die); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL rst_running got %b expected 0", running); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL rst_score got %0d expected 0", score); end
        do_reset(1'b0, 16'h0000);
        goto(10);
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_running got %b expected 0", running); end
        checks++; if (die !== 1'b0) begin errors++; $display("FAIL idle_die got %b expected 0", die); end
        checks++; if (field !== '0) begin errors++; $display("FAIL idle_field got %h expected 0", field); end
    endtask

    task automatic test_game;
        do_reset(1'b1, 16'h0100);
        goto(19);
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running got %b expected 1", running); end
        checks++; if (field !== '0) begin errors++; $display("FAIL pre_spawn got %h expected 0", field); end
        goto(20);
        exp_f = col_at(15, 16'hFF87);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL spawn1 got %h expected %h", field, exp_f); end
        bird_row = 16'h0010;
        goto(24);
        exp_f = col_at(14, 16'hFF87);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL scroll1 got %h expected %h", field, exp_f); end
        goto(40);
        exp_f = col_at(15, 16'hFC3F) | col_at(10, 16'hFF87);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL spawn2 got %h expected %h", field, exp_f); end
        goto(72);
        checks++; if (field[47:32] !== 16'hFF87) begin errors++; $display("FAIL at_bird got %h expected ff87", field[47:32]); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL score0 got %0d expected 0", score); end
        goto(76);
        checks++; if (score !== 8'd1) begin errors++; $display("FAIL score1 got %0d expected 1", score); end
        checks++; if (die !== 1'b0) begin errors++; $display("FAIL gap_die got %b expected 0", die); end
        bird_row = 16'h0100;
        goto(96);
        checks++; if (score !== 8'd2) begin errors++; $display("FAIL score2 got %0d expected 2", score); end
        goto(112);
        exp_f = col_at(2, 16'hE1FF) | col_at(7, 16'hFC3F) | col_at(12, 16'hFF87);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL field112 got %h expected %h", field, exp_f); end
        checks++; if (die !== 1'b0) begin errors++; $display("FAIL pre_hit_die got %b expected 0", die); end
        goto(113);
        checks++; if (die !== 1'b1) begin errors++; $display("FAIL hit_die got %b expected 1", die); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL dead_running got %b expected 0", running); end
        start = 1'b0;
        goto(114);
        checks++; if (die !== 1'b0) begin errors++; $display("FAIL die_pulse got %b expected 0", die); end
        goto(127);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL frozen got %h expected %h", field, exp_f); end
        checks++; if (die !== 1'b0) begin errors++; $display("FAIL dead_die got %b expected 0", die); end
        goto(128);
        checks++; if (field !== '0) begin errors++; $display("FAIL dead_clear got %h expected 0", field); end
        checks++; if (score !== 8'd2) begin errors++; $display("FAIL idle_score got %0d expected 2", score); end
    endtask

    task automatic test_idle_restart;
        start = 1'b1;
        goto(129);
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL restart_score got %0d expected 0", score); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL restart_running got %b expected 1", running); end
    endtask

    task automatic test_hit_tick;
        do_reset(1'b1, 16'h0100);
        goto(19);
        bird_row = 16'h0000;
        goto(20);
        checks++; if (die !== 1'b1) begin errors++; $display("FAIL off_die got %b expected 1", die); end
        checks++; if (field !== '0) begin errors++; $display("FAIL hit_noscroll got %h expected 0", field); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL hit_score got %0d expected 0", score); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL hit_running got %b expected 0", running); end
        reset = 1'b1;
        #1;
        checks++; if (die !== 1'b0) begin errors++; $display("FAIL async_die got %b expected 0", die); end
    endtask

    task automatic test_pause;
        do_reset(1'b1, 16'h0010);
        goto(24);
        exp_f = col_at(14, 16'hFF87);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL pause_pre got %h expected %h", field, exp_f); end
        start = 1'b0;
        goto(104);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL paused got %h expected %h", field, exp_f); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL pause_score got %0d expected 0", score); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL pause_running got %b expected 1", running); end
        start = 1'b1;
        goto(108);
        exp_f = col_at(13, 16'hFF87);
        checks++; if (field !== exp_f) begin errors++; $display("FAIL resume got %h expected %h", field, exp_f); end
        reset = 1'b1;
        #1;
        checks++; if (field !== '0) begin errors++; $display("FAIL async_field got %h expected 0", field); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL async_running got %b expected 0", running); end
        checks++; if (score !== 8'd0) begin errors++; $display("FAIL async_score got %0d expected 0", score); end
    endtask

    initial begin
        test_reset;
        test_game;
        test_idle_restart;
        test_hit_tick;
        test_pause;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
